// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants.
//   Opcode encodings (instr[6:0]) and the immediate-format classification
//   used by the decode stage and its immediate generator.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // Unlisted opcodes (including OP) carry no immediate.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      default:                  fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator (combinational).
//   instr : 32-bit instruction word
//   imm   : 32-bit immediate, sign-extended from instr[31]
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt(instr[6:0]))
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode / operand-fetch stage feeding the ID/EX pipeline register.
//   clk, rst                  : clock (rising edge), async active-high reset
//   id_valid/id_instr/id_pc   : instruction held in IF/ID
//   rf_a1, rf_a2              : register file read addresses (rs1, rs2)
//   rf_rs1_data, rf_rs2_data  : register file read data
//   mem_*                     : MEM-stage writer (bypass source, load hazard source)
//   wb_*                      : WB-stage writer (bypass source)
//   flush                     : EX redirect, kills the decode this cycle
//   stall_out                 : hold PC and IF/ID (unbypassable RAW hazard)
//   ex_*                      : ID/EX pipeline register contents
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  input  logic [WORD_SIZE-1:0] id_pc,
  output logic [4:0]           rf_a1,
  output logic [4:0]           rf_a2,
  input  logic [WORD_SIZE-1:0] rf_rs1_data,
  input  logic [WORD_SIZE-1:0] rf_rs2_data,
  input  logic                 mem_reg_write,
  input  logic                 mem_is_load,
  input  logic [4:0]           mem_rd,
  input  logic [WORD_SIZE-1:0] mem_result,
  input  logic                 wb_reg_write,
  input  logic [4:0]           wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 flush,
  output logic                 stall_out,
  output logic                 ex_valid,
  output logic [WORD_SIZE-1:0] ex_pc,
  output logic [WORD_SIZE-1:0] ex_rs1_val,
  output logic [WORD_SIZE-1:0] ex_rs2_val,
  output logic [WORD_SIZE-1:0] ex_imm,
  output logic [4:0]           ex_rd,
  output logic [6:0]           ex_opcode,
  output logic [2:0]           ex_funct3,
  output logic                 ex_funct7b5,
  output logic                 ex_reg_write,
  output logic                 ex_is_load,
  output logic                 ex_is_store
);

  logic [6:0]           opcode;
  logic [4:0]           rs1, rs2, rd;
  logic                 rs1_used, rs2_used;
  logic                 writes_rd;
  logic [31:0]          imm32;
  logic [WORD_SIZE-1:0] imm_ext;
  logic [WORD_SIZE-1:0] rs1_val, rs2_val;
  logic                 hz;

  assign opcode = id_instr[6:0];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign rd     = id_instr[11:7];
  assign rf_a1  = rs1;
  assign rf_a2  = rs2;

  assign rs1_used  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used  = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
  assign writes_rd = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != 5'd0);

  imm_gen u_imm_gen (
    .instr (id_instr),
    .imm   (imm32)
  );

  assign imm_ext = WORD_SIZE'($signed(imm32));

  // A non-load MEM result is newer than WB, which is newer than the RF read.
  function automatic logic [WORD_SIZE-1:0] resolve(
    input logic [4:0]           rs,
    input logic [WORD_SIZE-1:0] rf_data,
    input logic                 m_we,
    input logic                 m_ld,
    input logic [4:0]           m_rd,
    input logic [WORD_SIZE-1:0] m_res,
    input logic                 w_we,
    input logic [4:0]           w_rd,
    input logic [WORD_SIZE-1:0] w_dat
  );
    logic [WORD_SIZE-1:0] val;
    if (rs == 5'd0)                            val = '0;
    else if (m_we && !m_ld && m_rd == rs)      val = m_res;
    else if (w_we && w_rd == rs)               val = w_dat;
    else                                       val = rf_data;
    return val;
  endfunction

  // Producer still in EX, or a load in MEM whose data is not yet available.
  function automatic logic src_hazard(
    input logic [4:0] rs,
    input logic       e_valid,
    input logic       e_we,
    input logic [4:0] e_rd,
    input logic       m_we,
    input logic       m_ld,
    input logic [4:0] m_rd
  );
    return (rs != 5'd0) &&
           ((e_valid && e_we && e_rd == rs) || (m_we && m_ld && m_rd == rs));
  endfunction

  always_comb begin
    rs1_val = resolve(rs1, rf_rs1_data, mem_reg_write, mem_is_load, mem_rd, mem_result,
                      wb_reg_write, wb_rd, wb_data);
    rs2_val = resolve(rs2, rf_rs2_data, mem_reg_write, mem_is_load, mem_rd, mem_result,
                      wb_reg_write, wb_rd, wb_data);
    hz = id_valid &&
         ((rs1_used && src_hazard(rs1, ex_valid, ex_reg_write, ex_rd,
                                  mem_reg_write, mem_is_load, mem_rd)) ||
          (rs2_used && src_hazard(rs2, ex_valid, ex_reg_write, ex_rd,
                                  mem_reg_write, mem_is_load, mem_rd)));
  end

  assign stall_out = hz && !flush;

  // Control flags are gated with validity on capture and cleared on bubbles,
  // so they read 0 whenever ex_valid is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_is_store  <= 1'b0;
    end else if (flush || hz) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_is_store  <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_val   <= rs1_used ? rs1_val : '0;
      ex_rs2_val   <= rs2_used ? rs2_val : '0;
      ex_imm       <= imm_ext;
      ex_rd        <= rd;
      ex_opcode    <= opcode;
      ex_funct3    <= id_instr[14:12];
      ex_funct7b5  <= id_instr[30];
      ex_reg_write <= id_valid && writes_rd;
      ex_is_load   <= id_valid && (opcode == OP_LOAD);
      ex_is_store  <= id_valid && (opcode == OP_STORE);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model plus directed vectors.
module tb_id_ex_stage;

  localparam int W = 32;

  localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011, T_OPI = 7'b0010011, T_OP = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, mem_reg_write, mem_is_load, wb_reg_write, flush;
  logic [31:0] id_instr;
  logic [W-1:0] id_pc, rf_rs1_data, rf_rs2_data, mem_result, wb_data;
  logic [4:0] mem_rd, wb_rd, rf_a1, rf_a2;
  logic stall_out, ex_valid, ex_funct7b5, ex_reg_write, ex_is_load, ex_is_store;
  logic [W-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] ex_rd;
  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;

  id_ex_stage #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          f7, rw, ld, st;
  } ex_t;

  ex_t m;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == T_LUI || op == T_AUIPC || op == T_JAL);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == T_OP || op == T_ST || op == T_BR);
  endfunction

  // Immediate reconstructed with signed integer arithmetic on the fields.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int s;
    int r;
    s = int'(i);
    case (i[6:0])
      T_LD, T_OPI, T_JALR: r = s >>> 20;
      T_ST:  r = ((s >>> 25) * 32) + int'(i[11:7]);
      T_BR:  r = ((s >>> 31) * 4096) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      T_LUI, T_AUIPC: r = int'(i & 32'hFFFFF000);
      T_JAL: r = ((s >>> 31) * 1048576) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                 + int'(i[30:21]) * 2;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (mem_reg_write && !mem_is_load && mem_rd == r) return mem_result;
    if (wb_reg_write && wb_rd == r) return wb_data;
    return rf;
  endfunction

  function automatic bit model_hz();
    logic [4:0] srcs [2];
    bit uses [2];
    bit h;
    h = 0;
    srcs[0] = id_instr[19:15];
    srcs[1] = id_instr[24:20];
    uses[0] = reads_rs1(id_instr[6:0]);
    uses[1] = reads_rs2(id_instr[6:0]);
    for (int k = 0; k < 2; k++) begin
      if (uses[k] && srcs[k] != 5'd0) begin
        if (m.valid && m.rw && m.rd == srcs[k]) h = 1;
        if (mem_reg_write && mem_is_load && mem_rd == srcs[k]) h = 1;
      end
    end
    return id_valid && h;
  endfunction

  always @(posedge clk or posedge rst) begin
    ex_t nx;
    nx = m;
    if (rst) begin
      nx = '{default: 0};
    end else if (flush || model_hz()) begin
      nx.valid = 0; nx.rw = 0; nx.ld = 0; nx.st = 0;
    end else begin
      nx.valid = id_valid;
      nx.pc    = id_pc;
      nx.a     = reads_rs1(id_instr[6:0]) ? model_operand(id_instr[19:15], rf_rs1_data) : 32'd0;
      nx.b     = reads_rs2(id_instr[6:0]) ? model_operand(id_instr[24:20], rf_rs2_data) : 32'd0;
      nx.imm   = model_imm(id_instr);
      nx.rd    = id_instr[11:7];
      nx.op    = id_instr[6:0];
      nx.f3    = id_instr[14:12];
      nx.f7    = id_instr[30];
      nx.rw    = id_valid && id_instr[11:7] != 5'd0 && id_instr[6:0] != T_ST && id_instr[6:0] != T_BR;
      nx.ld    = id_valid && id_instr[6:0] == T_LD;
      nx.st    = id_valid && id_instr[6:0] == T_ST;
    end
    m <= nx;
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    check("stall_out", {31'b0, stall_out}, {31'b0, model_hz() && !flush});
    check("rf_a1", {27'b0, rf_a1}, {27'b0, id_instr[19:15]});
    check("rf_a2", {27'b0, rf_a2}, {27'b0, id_instr[24:20]});
    check("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    check("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.rw});
    check("ex_is_load", {31'b0, ex_is_load}, {31'b0, m.ld});
    check("ex_is_store", {31'b0, ex_is_store}, {31'b0, m.st});
    if (m.valid) begin
      check("ex_pc", ex_pc, m.pc);
      check("ex_rs1_val", ex_rs1_val, m.a);
      check("ex_rs2_val", ex_rs2_val, m.b);
      check("ex_imm", ex_imm, m.imm);
      check("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
      check("ex_opcode", {25'b0, ex_opcode}, {25'b0, m.op});
      check("ex_funct3", {29'b0, ex_funct3}, {29'b0, m.f3});
      check("ex_funct7b5", {31'b0, ex_funct7b5}, {31'b0, m.f7});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    id_valid = 0; id_instr = 32'h00000013; id_pc = '0;
    rf_rs1_data = '0; rf_rs2_data = '0;
    mem_reg_write = 0; mem_is_load = 0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 0; wb_rd = '0; wb_data = '0; flush = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl_instr [6];

  initial begin
    tbl_instr[0] = 32'h123453B7; // lui x7,0x12345
    tbl_instr[1] = 32'hFE2088E3; // beq x1,x2,-16
    tbl_instr[2] = 32'hFF5FF0EF; // jal x1,-12
    tbl_instr[3] = 32'h000080E7; // jalr x1,0(x1)
    tbl_instr[4] = 32'hFFF18193; // addi x3,x3,-1
    tbl_instr[5] = 32'h402081B3; // sub x3,x1,x2

    idle();
    repeat (2) @(negedge clk);
    #1 rst = 0;

    // Reset state
    #1;
    check("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("reset_stall", {31'b0, stall_out}, 32'd0);

    // WB bypass over stale RF
    next_cycle();
    id_valid = 1; id_instr = 32'h00028333; id_pc = 32'h100;
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    after_edge();
    check("wb_fwd_rs1", ex_rs1_val, 32'hDEADBEEF);
    check("wb_fwd_rd", {27'b0, ex_rd}, 32'd6);
    check("wb_fwd_valid", {31'b0, ex_valid}, 32'd1);

    // MEM wins over WB
    next_cycle();
    id_valid = 1; id_instr = 32'h00028333; id_pc = 32'h104;
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'h11111111;
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'h22222222;
    after_edge();
    check("mem_fwd_rs1", ex_rs1_val, 32'h11111111);

    // Load-use: lw x5,0(x1) then add x6,x5,x1
    next_cycle();
    id_valid = 1; id_instr = 32'h0000A283; id_pc = 32'h108; rf_rs1_data = 32'h1000;
    after_edge();
    check("lw_in_ex", {31'b0, ex_is_load}, 32'd1);
    next_cycle();
    id_valid = 1; id_instr = 32'h00128333; id_pc = 32'h10C; rf_rs2_data = 32'd7;
    #1 check("lu_stall1", {31'b0, stall_out}, 32'd1);
    after_edge();
    check("lu_bubble1", {31'b0, ex_valid}, 32'd0);
    next_cycle();
    id_valid = 1; id_instr = 32'h00128333; id_pc = 32'h10C; rf_rs2_data = 32'd7;
    mem_reg_write = 1; mem_is_load = 1; mem_rd = 5; mem_result = 32'h0BADBAD0;
    #1 check("lu_stall2", {31'b0, stall_out}, 32'd1);
    after_edge();
    check("lu_bubble2", {31'b0, ex_valid}, 32'd0);
    check("lu_bubble2_rw", {31'b0, ex_reg_write}, 32'd0);
    next_cycle();
    id_valid = 1; id_instr = 32'h00128333; id_pc = 32'h10C; rf_rs2_data = 32'd7;
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'hCAFEF00D;
    #1 check("lu_nostall", {31'b0, stall_out}, 32'd0);
    after_edge();
    check("lu_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_rs1", ex_rs1_val, 32'hCAFEF00D);
    check("lu_rs2", ex_rs2_val, 32'd7);

    // x0 never forwards or stalls
    next_cycle();
    id_valid = 1; id_instr = 32'h00000333; id_pc = 32'h110;
    rf_rs1_data = 32'h99; rf_rs2_data = 32'h99;
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'd5;
    #1 check("x0_nostall", {31'b0, stall_out}, 32'd0);
    after_edge();
    check("x0_rs1", ex_rs1_val, 32'd0);
    check("x0_rs2", ex_rs2_val, 32'd0);

    // Flush during a hazard
    next_cycle();
    id_valid = 1; id_instr = 32'h0000A283; id_pc = 32'h114;
    after_edge();
    next_cycle();
    id_valid = 1; id_instr = 32'h00128333; id_pc = 32'h118; flush = 1;
    #1 check("flush_nostall", {31'b0, stall_out}, 32'd0);
    after_edge();
    check("flush_bubble", {31'b0, ex_valid}, 32'd0);

    // Store decode
    next_cycle();
    id_valid = 1; id_instr = 32'hFE20AE23; id_pc = 32'h11C;
    rf_rs1_data = 32'h2000; rf_rs2_data = 32'h55;
    after_edge();
    check("sw_imm", ex_imm, 32'hFFFFFFFC);
    check("sw_is_store", {31'b0, ex_is_store}, 32'd1);
    check("sw_reg_write", {31'b0, ex_reg_write}, 32'd0);

    // Assorted formats, checked by the model; lui pinned by hand
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      id_valid = 1; id_instr = tbl_instr[k]; id_pc = 32'h200 + 32'(k * 4);
      rf_rs1_data = 32'hA0 + 32'(k); rf_rs2_data = 32'hB0 + 32'(k);
      wb_reg_write = 1; wb_rd = 2; wb_data = 32'h77;
      after_edge();
      if (k == 0) check("lui_imm", ex_imm, 32'h12345000);
    end

    // id_valid low: captured bubble
    next_cycle();
    after_edge();
    check("idle_invalid", {31'b0, ex_valid}, 32'd0);

    // Asynchronous reset mid-stream
    next_cycle();
    id_valid = 1; id_instr = 32'hFFF18193; id_pc = 32'h300; rf_rs1_data = 32'h42;
    after_edge();
    check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    #1 rst = 1;
    #1;
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_rs1", ex_rs1_val, 32'd0);
    check("rst_imm", ex_imm, 32'd0);
    check("rst_rd", {27'b0, ex_rd}, 32'd0);
    check("rst_opcode", {25'b0, ex_opcode}, 32'd0);
    check("rst_rw", {31'b0, ex_reg_write}, 32'd0);
    next_cycle();
    rst = 0;
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
